microwave_cook_controller: RTL and testbench
============================================

# microwave_cook_controller

Sequencing controller for the microwave timer path. Accepts BCD digits and a valid strobe from the timer/input-and-control module and assembles them into an M:SS cook time. It gates the keypad through `enablen`, counts the time down on rising edges of `pgt_1Hz`, and drives the magnetron, display digits and end-of-cook beeper. It sits between the timer/input module and the display and power stage.

## Interface
- `DONE_CYCLES`, default 200: length of the DONE/beep interval in `clock_100Hz` cycles (2 s).
- `clock_100Hz  input  1  system clock; all state changes on its rising edge`
- `clear  input  1  synchronous, active-high reset`
- `D  input  4  BCD digit from the keypad encoder`
- `loadn  input  1  active-low digit-valid from the encoder; stays low while the key is held`
- `pgt_1Hz  input  1  1 Hz tick source (meaningful only while enablen=1)`
- `start  input  1  start/resume request, level`
- `stop  input  1  stop/cancel request, level`
- `door_closed  input  1  1 = door closed`
- `enablen  output  1  keypad enable to the encoder; 0 = keypad live`
- `mag_on  output  1  magnetron drive`
- `min_ones, sec_tens, sec_ones  output  4 each  BCD display of remaining/entered time`
- `beep  output  1  high throughout DONE`

## Operation
- One clock and one reset. Reset is synchronous and active-high.
- States: IDLE, SET, COOK, PAUSE, DONE. Reset goes to IDLE with all digits 0, `mag_on`=0, `beep`=0, `enablen`=0.
- Edge detect:
  - Each of `loadn`, `pgt_1Hz` and `start` has a one-flop history register, cleared by reset to its inactive level.
  - Digit event: `loadn`=0 now and 1 at the previous edge.
  - Tick: `pgt_1Hz`=1 now and 0 at the previous edge.
  - Start event: rising edge of `start`.
- Digit entry (IDLE or SET only):
  - A digit event with `D`≤9 shifts left: `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`D`. IDLE→SET.
  - `D`>9 is ignored. One shift per key press, regardless of hold time.
- Start acceptance (from SET or PAUSE):
  - Requires `door_closed`=1, a time ≠ 000, and `sec_tens`≤5.
  - Otherwise the event is dropped and the state is unchanged.
  - SET/PAUSE→COOK.
- COOK:
  - `mag_on`=1, `enablen`=1.
  - Each tick decrements M:SS in BCD. `sec_ones` borrows from `sec_tens`; `sec_tens` borrows from `min_ones`, wrapping to 5.
  - A decrement reaching 0:00 goes to DONE on the same edge.
- PAUSE: `mag_on`=0, `enablen`=1, digits held.
- DONE:
  - `beep`=1, `mag_on`=0, `enablen`=1.
  - After exactly `DONE_CYCLES` cycles, go to IDLE.
- Stop:
  - SET→IDLE with digits cleared.
  - COOK→PAUSE.
  - PAUSE→IDLE with digits cleared.
  - DONE→IDLE immediately.
  - Ignored in IDLE.
- Door open (`door_closed`=0) in COOK → PAUSE.
- Priority, highest first: `clear`, stop, door open, tick, start, digit.
  - Stop or door open in the same cycle as a tick: pause with no decrement.
  - Start and stop together: stop wins, and the start event is consumed.
- Ticks outside COOK are discarded. Digit events outside IDLE/SET are discarded.

## Timing
- All outputs are registered.
- Every transition and digit change is visible one cycle after the clock edge at which the triggering event is sampled.
- Tick to digit update: same edge at which `pgt_1Hz` is first sampled high. There is no added pipeline.
- `enablen` rises on the same edge as entry into COOK. The first tick is counted at the first `pgt_1Hz` rise after that edge.
  - If `pgt_1Hz` is already high at entry, its history register must read 0 at entry, so that tick is counted. History is loaded as 0 on every transition into COOK.
- DONE lasts exactly `DONE_CYCLES` cycles of `beep`=1.
- Reset mid-COOK: on the next edge, `mag_on`=0, state IDLE, digits 000. No beep.

## Structure
- Shared package `microwave_pkg`:
  - state encoding (IDLE, SET, COOK, PAUSE, DONE)
  - BCD constants (`BCD_NINE`, `BCD_FIVE`)
  - the `DONE_CYCLES` default
- Sub-module `bcd_mss_down_counter`: three BCD digit registers with load-shift, decrement, clear and a zero flag.
- The FSM, edge detectors and DONE interval counter live at top level.

## Test plan
- Enter keys 1,3,0 → display 1:30, state SET. Start with the door closed → `mag_on`=1, `enablen`=1. Three ticks → 1:27.
- Load 1:00, start, one tick → 0:59. Load 0:01, start, one tick → 0:00, DONE, `beep`=1 for exactly 200 cycles, then IDLE.
- Open the door during COOK at 0:45 with a tick in the same cycle → PAUSE, display stays 0:45, `mag_on`=0. Close the door and start → COOK resumes from 0:45.
- Enter 0:75, then start → rejected, stays SET. Enter 000, then start → rejected. Start with the door open → rejected.
- Assert start and stop together in PAUSE → IDLE, digits 000. Hold one key across 50 cycles → exactly one shift. `D`=4'hA → no shift.
- Assert `clear` during COOK at 2:10 → next cycle `mag_on`=0, IDLE, 000, `enablen`=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  localparam int DONE_CYCLES_DEFAULT = 200;

endpackage

// File: rtl/bcd_mss_down_counter.sv
// M:SS time register: three BCD digits with shift-in entry, BCD countdown,
// clear, and zero flags for the controlling FSM.
module bcd_mss_down_counter
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [3:0] shift_digit,
  input  logic       dec_en,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       is_zero,
  output logic       dec_hits_zero
);

  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  always_comb begin
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (clr) begin
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (shift_en) begin
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = shift_digit;
    end else if (dec_en) begin
      // Seconds tens wraps to 5, not 9: the display is M:SS.
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = BCD_NINE;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = BCD_FIVE;
          min_ones_d = min_ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign min_ones      = min_ones_q;
  assign sec_tens      = sec_tens_q;
  assign sec_ones      = sec_ones_q;
  assign is_zero       = (min_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  assign dec_hits_zero = (min_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

endmodule

// File: rtl/microwave_cook_controller.sv
// Microwave cook sequencer: keypad time entry, start/stop/door handling,
// 1 Hz countdown, magnetron drive and end-of-cook beep interval.
module microwave_cook_controller
  import microwave_pkg::*;
#(
  parameter int DONE_CYCLES = DONE_CYCLES_DEFAULT
) (
  input  logic       clock_100Hz,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       beep
);

  localparam int CNT_W = $clog2(DONE_CYCLES + 1);

  state_t             state_q, state_d;
  logic               loadn_prev_q, loadn_prev_d;
  logic               pgt_prev_q, pgt_prev_d;
  logic               start_prev_q, start_prev_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic               mag_on_q, mag_on_d;
  logic               enablen_q, enablen_d;
  logic               beep_q, beep_d;

  logic cnt_clr, cnt_shift, cnt_dec;
  logic is_zero, dec_hits_zero;
  logic digit_ev, tick_ev, start_ev, start_ok, digit_ok;

  assign digit_ev = !loadn && loadn_prev_q;
  assign tick_ev  = pgt_1Hz && !pgt_prev_q;
  assign start_ev = start && !start_prev_q;
  assign digit_ok = digit_ev && (D <= BCD_NINE);
  assign start_ok = door_closed && !is_zero && (sec_tens <= BCD_FIVE);

  always_comb begin
    state_d    = state_q;
    done_cnt_d = done_cnt_q;
    cnt_clr    = 1'b0;
    cnt_shift  = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (digit_ok) begin
          cnt_shift = 1'b1;
          state_d   = ST_SET;
        end
      end
      ST_SET: begin
        if (stop) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ev && start_ok) begin
          state_d = ST_COOK;
        end else if (digit_ok) begin
          cnt_shift = 1'b1;
        end
      end
      ST_COOK: begin
        if (stop || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick_ev) begin
          cnt_dec = 1'b1;
          if (dec_hits_zero) begin
            state_d    = ST_DONE;
            done_cnt_d = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ev && start_ok) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop || (done_cnt_q == CNT_W'(DONE_CYCLES - 1))) begin
          state_d = ST_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    loadn_prev_d = loadn;
    start_prev_d = start;
    // Entering COOK forgets the old 1 Hz level so an already-high tick counts.
    pgt_prev_d   = ((state_d == ST_COOK) && (state_q != ST_COOK)) ? 1'b0 : pgt_1Hz;
    mag_on_d     = (state_d == ST_COOK);
    beep_d       = (state_d == ST_DONE);
    enablen_d    = (state_d == ST_COOK) || (state_d == ST_PAUSE) || (state_d == ST_DONE);
  end

  always_ff @(posedge clock_100Hz) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      loadn_prev_q <= 1'b1;
      pgt_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      done_cnt_q   <= '0;
      mag_on_q     <= 1'b0;
      enablen_q    <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      loadn_prev_q <= loadn_prev_d;
      pgt_prev_q   <= pgt_prev_d;
      start_prev_q <= start_prev_d;
      done_cnt_q   <= done_cnt_d;
      mag_on_q     <= mag_on_d;
      enablen_q    <= enablen_d;
      beep_q       <= beep_d;
    end
  end

  bcd_mss_down_counter u_counter (
    .clk           (clock_100Hz),
    .srst          (clear),
    .clr           (cnt_clr),
    .shift_en      (cnt_shift),
    .shift_digit   (D),
    .dec_en        (cnt_dec),
    .min_ones      (min_ones),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .is_zero       (is_zero),
    .dec_hits_zero (dec_hits_zero)
  );

  assign mag_on  = mag_on_q;
  assign enablen = enablen_q;
  assign beep    = beep_q;

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed scenario bench for microwave_cook_controller.
module tb_microwave_cook_controller;
  import microwave_pkg::*;

  logic       clk = 1'b0;
  logic       clear, loadn, pgt_1Hz, start, stop, door_closed;
  logic [3:0] D;
  logic       enablen, mag_on, beep;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic [11:0] disp;
  int checks = 0;
  int failures = 0;

  assign disp = {min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  microwave_cook_controller #(.DONE_CYCLES(200)) dut (
    .clock_100Hz (clk),
    .clear       (clear),
    .D           (D),
    .loadn       (loadn),
    .pgt_1Hz     (pgt_1Hz),
    .start       (start),
    .stop        (stop),
    .door_closed (door_closed),
    .enablen     (enablen),
    .mag_on      (mag_on),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .beep        (beep)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    D = d; loadn = 1'b0; cyc(1);
    loadn = 1'b1; cyc(1);
  endtask

  task automatic tick_pulse();
    pgt_1Hz = 1'b1; cyc(1);
    pgt_1Hz = 1'b0; cyc(1);
  endtask

  task automatic start_pulse();
    start = 1'b1; cyc(1);
    start = 1'b0; cyc(1);
  endtask

  task automatic stop_pulse();
    stop = 1'b1; cyc(1);
    stop = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    clear = 1'b1; cyc(3);
    checks++; if (disp !== 12'h000) begin failures++; $display("FAIL reset_digits got=%h exp=000", disp); end
    checks++; if (mag_on !== 1'b0 || beep !== 1'b0 || enablen !== 1'b0) begin failures++; $display("FAIL reset_outputs got mag=%b beep=%b en=%b exp 0 0 0", mag_on, beep, enablen); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    clear = 1'b0; cyc(1);
    $display("tb: reset done");
  endtask

  task automatic test_entry_cook();
    press(4'd1); press(4'd3); press(4'd0);
    checks++; if (disp !== 12'h130) begin failures++; $display("FAIL entry_digits got=%h exp=130", disp); end
    checks++; if (dut.state_q !== ST_SET) begin failures++; $display("FAIL entry_state got=%0d exp=%0d", dut.state_q, ST_SET); end
    start_pulse();
    checks++; if (mag_on !== 1'b1 || enablen !== 1'b1) begin failures++; $display("FAIL cook_outputs got mag=%b en=%b exp 1 1", mag_on, enablen); end
    repeat (3) tick_pulse();
    checks++; if (disp !== 12'h127) begin failures++; $display("FAIL three_ticks got=%h exp=127", disp); end
    stop_pulse(); stop_pulse();
    checks++; if (dut.state_q !== ST_IDLE || disp !== 12'h000) begin failures++; $display("FAIL stop_twice got state=%0d disp=%h exp IDLE 000", dut.state_q, disp); end
    $display("tb: entry 1:30 cook three ticks -> %h", disp);
  endtask

  task automatic test_minute_borrow();
    press(4'd1); press(4'd0); press(4'd0);
    start_pulse(); tick_pulse();
    checks++; if (disp !== 12'h059) begin failures++; $display("FAIL minute_borrow got=%h exp=059", disp); end
    stop_pulse(); stop_pulse();
    $display("tb: 1:00 one tick -> %h", disp);
  endtask

  task automatic test_done();
    int beep_cnt;
    press(4'd0); press(4'd0); press(4'd1);
    start_pulse();
    pgt_1Hz = 1'b1; cyc(1);
    checks++; if (dut.state_q !== ST_DONE || disp !== 12'h000) begin failures++; $display("FAIL done_entry got state=%0d disp=%h exp DONE 000", dut.state_q, disp); end
    checks++; if (beep !== 1'b1 || mag_on !== 1'b0 || enablen !== 1'b1) begin failures++; $display("FAIL done_outputs got beep=%b mag=%b en=%b exp 1 0 1", beep, mag_on, enablen); end
    pgt_1Hz = 1'b0;
    beep_cnt = (beep === 1'b1) ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (beep !== 1'b1) break;
      beep_cnt++;
    end
    checks++; if (beep_cnt != 200) begin failures++; $display("FAIL beep_length got=%0d exp=200", beep_cnt); end
    checks++; if (dut.state_q !== ST_IDLE || enablen !== 1'b0) begin failures++; $display("FAIL after_done got state=%0d en=%b exp IDLE 0", dut.state_q, enablen); end
    $display("tb: 0:01 done, beep cycles=%0d", beep_cnt);
  endtask

  task automatic test_door_pause();
    press(4'd0); press(4'd4); press(4'd6);
    start_pulse(); tick_pulse();
    checks++; if (disp !== 12'h045) begin failures++; $display("FAIL door_setup got=%h exp=045", disp); end
    door_closed = 1'b0; pgt_1Hz = 1'b1; cyc(1);
    checks++; if (dut.state_q !== ST_PAUSE || disp !== 12'h045 || mag_on !== 1'b0) begin failures++; $display("FAIL door_pause got state=%0d disp=%h mag=%b exp PAUSE 045 0", dut.state_q, disp, mag_on); end
    door_closed = 1'b1; cyc(2);
    start = 1'b1; cyc(1);
    checks++; if (dut.state_q !== ST_COOK || disp !== 12'h045 || mag_on !== 1'b1) begin failures++; $display("FAIL resume got state=%0d disp=%h mag=%b exp COOK 045 1", dut.state_q, disp, mag_on); end
    start = 1'b0; cyc(1);
    checks++; if (disp !== 12'h044) begin failures++; $display("FAIL high_tick_at_entry got=%h exp=044", disp); end
    pgt_1Hz = 1'b0; cyc(1);
    stop_pulse(); stop_pulse();
    $display("tb: door pause at 0:45 and resume");
  endtask

  task automatic test_reject();
    press(4'd0); press(4'd7); press(4'd5);
    start_pulse();
    checks++; if (dut.state_q !== ST_SET || disp !== 12'h075 || mag_on !== 1'b0) begin failures++; $display("FAIL reject_075 got state=%0d disp=%h mag=%b exp SET 075 0", dut.state_q, disp, mag_on); end
    stop_pulse();
    press(4'd0); press(4'd0); press(4'd0);
    start_pulse();
    checks++; if (dut.state_q !== ST_SET || mag_on !== 1'b0) begin failures++; $display("FAIL reject_zero got state=%0d mag=%b exp SET 0", dut.state_q, mag_on); end
    stop_pulse();
    press(4'd1); press(4'd0); press(4'd0);
    door_closed = 1'b0; start_pulse();
    checks++; if (dut.state_q !== ST_SET || mag_on !== 1'b0) begin failures++; $display("FAIL reject_door got state=%0d mag=%b exp SET 0", dut.state_q, mag_on); end
    door_closed = 1'b1; stop_pulse();
    checks++; if (dut.state_q !== ST_IDLE || disp !== 12'h000) begin failures++; $display("FAIL set_stop got state=%0d disp=%h exp IDLE 000", dut.state_q, disp); end
    $display("tb: start rejections");
  endtask

  task automatic test_start_stop_pause();
    press(4'd0); press(4'd3); press(4'd0);
    start_pulse(); stop_pulse();
    checks++; if (dut.state_q !== ST_PAUSE || disp !== 12'h030 || enablen !== 1'b1) begin failures++; $display("FAIL cook_stop got state=%0d disp=%h en=%b exp PAUSE 030 1", dut.state_q, disp, enablen); end
    start = 1'b1; stop = 1'b1; cyc(1);
    checks++; if (dut.state_q !== ST_IDLE || disp !== 12'h000) begin failures++; $display("FAIL start_stop got state=%0d disp=%h exp IDLE 000", dut.state_q, disp); end
    start = 1'b0; stop = 1'b0; cyc(1);
    $display("tb: start+stop in pause");
  endtask

  task automatic test_key_hold();
    D = 4'd2; loadn = 1'b0; cyc(50);
    loadn = 1'b1; cyc(1);
    checks++; if (disp !== 12'h002 || dut.state_q !== ST_SET) begin failures++; $display("FAIL key_hold got disp=%h state=%0d exp 002 SET", disp, dut.state_q); end
    press(4'hA);
    checks++; if (disp !== 12'h002) begin failures++; $display("FAIL invalid_digit got=%h exp=002", disp); end
    press(4'd7);
    checks++; if (disp !== 12'h027) begin failures++; $display("FAIL shift_after got=%h exp=027", disp); end
    stop_pulse();
    $display("tb: key hold and invalid digit");
  endtask

  task automatic test_clear_cook();
    press(4'd2); press(4'd1); press(4'd0);
    start_pulse();
    checks++; if (dut.state_q !== ST_COOK || disp !== 12'h210) begin failures++; $display("FAIL clear_setup got state=%0d disp=%h exp COOK 210", dut.state_q, disp); end
    clear = 1'b1; cyc(1);
    checks++; if (mag_on !== 1'b0 || enablen !== 1'b0 || beep !== 1'b0) begin failures++; $display("FAIL clear_outputs got mag=%b en=%b beep=%b exp 0 0 0", mag_on, enablen, beep); end
    checks++; if (dut.state_q !== ST_IDLE || disp !== 12'h000) begin failures++; $display("FAIL clear_state got state=%0d disp=%h exp IDLE 000", dut.state_q, disp); end
    clear = 1'b0; cyc(1);
    $display("tb: clear during cook");
  endtask

  initial begin
    clear = 1'b1; loadn = 1'b1; pgt_1Hz = 1'b0; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; D = 4'd0;
    test_reset();
    test_entry_cook();
    test_minute_borrow();
    test_done();
    test_door_pause();
    test_reject();
    test_start_stop_pause();
    test_key_hold();
    test_clear_cook();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
